trap_ctrl: RTL and testbench
============================

# trap_ctrl

Sequential trap and return controller sitting at the writeback boundary of the TCORE pipeline. It samples the retiring instruction's exception status and `NUM_IRQ` level-sensitive interrupt lines, and arbitrates by fixed priority. It then runs a short FSM that suppresses commit, flushes the pipe, pulses CSR trap or mret updates, and holds a PC redirect until fetch accepts it. It generalises the combinational writeback trap decode with interrupts, `mret`, vectored dispatch, `mtval`, and a redirect handshake.

## Interface
- `XLEN`, 32, datapath and CSR width
- `NUM_IRQ`, 4, interrupt line count, legal range 1..16
- `IRQ_BASE_CAUSE`, 16, cause code of `irq_i[0]`; line n reports `IRQ_BASE_CAUSE+n`

Ports:
- `clk_i` in 1: single clock
- `rst_ni` in 1: reset, synchronous, active-low
- `wb_valid_i` in 1: instruction present in WB this cycle
- `wb_pc_i` in XLEN: PC of the WB instruction
- `exc_type_i` in `exc_type_e`: WB exception, `NO_EXCEPTION` if none
- `exc_tval_i` in XLEN: faulting address or instruction
- `is_mret_i` in 1: WB instruction is `mret`
- `irq_i` in NUM_IRQ: interrupt lines, level
- `irq_en_i` in NUM_IRQ: `mie` enable bits
- `mie_i` in 1: `mstatus.MIE`
- `mtvec_i` in XLEN: trap vector CSR
- `mepc_i` in XLEN: current `mepc` CSR
- `redirect_ready_i` in 1: fetch accepts redirect
- `commit_o` out 1: WB register-file write permitted
- `flush_o` out 1: kill IF..MEM contents
- `busy_o` out 1: FSM not in IDLE
- `redirect_valid_o` out 1, `redirect_pc_o` out XLEN: fetch redirect
- `csr_trap_we_o` out 1: one-cycle strobe to write `mepc`, `mcause`, `mtval` and update `mstatus`
- `csr_mepc_o`, `csr_mcause_o`, `csr_mtval_o` out XLEN: trap CSR values
- `csr_mret_o` out 1: one-cycle strobe to restore `mstatus`

## Operation
- Pending set: `irq_i & irq_en_i`, gated by `mie_i`. The lowest index has highest priority.
- States: IDLE, TRAP_WR, MRET_WR, REDIRECT.
- IDLE, `wb_valid_i`=1, pending interrupt present:
  - The interrupt wins over any exception of the same instruction.
  - Latch mepc=`wb_pc_i`, mcause={1, `IRQ_BASE_CAUSE`+idx}, mtval=0.
  - Go to TRAP_WR.
- IDLE, exception present, no pending interrupt:
  - mcause uses the codes INSTR_ACCESS_FAULT=1, ILLEGAL=2, EBREAK=3, LOAD_MIS=4, LOAD_AF=5, STORE_MIS=6, STORE_AF=7, ECALL=11. Bit XLEN-1 is 0.
  - mtval=`exc_tval_i`, except EBREAK and ECALL, which use 0.
  - Go to TRAP_WR.
- IDLE, `is_mret_i`, with no exception and no interrupt: go to MRET_WR.
- Detection cycle (combinational): `commit_o`=0 and `flush_o`=1. Otherwise in IDLE, `commit_o`=`wb_valid_i`.
- TRAP_WR:
  - `csr_trap_we_o`=1 with latched values.
  - Latch target = {`mtvec_i`[XLEN-1:2],2'b00}, plus 4×cause code when vectored.
  - Go to REDIRECT.
- MRET_WR: `csr_mret_o`=1, latch target=`mepc_i`, go to REDIRECT.
- REDIRECT: `redirect_valid_o`=1 with a stable `redirect_pc_o`. On `redirect_ready_i`=1, go to IDLE.
- When `busy_o`=1: `flush_o`=1, `commit_o`=0, and `wb_valid_i`, `irq_i` and `is_mret_i` are ignored.

## Timing
- Reset value: state IDLE. Every output is 0, including the latched CSR values and `redirect_pc_o`.
- Reset asserted mid-sequence: back to IDLE next edge. No CSR strobe, and any pending redirect is dropped.
- Cycle sequence from detection at cycle 0:
  - cycle 1: CSR strobe
  - cycle 2: `redirect_valid_o`
  - earliest return to IDLE: cycle 3, when ready is high at cycle 2
- `redirect_ready_i` low: `redirect_valid_o` and `redirect_pc_o` are held indefinitely.
- Interrupts are sampled only in the IDLE detection cycle. An interrupt deasserted before then is lost, which is correct for level semantics.
- Each strobe is exactly one cycle per trap or mret.

## Configuration
- `TCORE_VECTORED_IRQ_EN` defined:
  - When `mtvec_i`[1:0]=2'b01 and the trap is an interrupt, the target is base+4×(`IRQ_BASE_CAUSE`+idx).
  - Exceptions always use base.
- Undefined: `mtvec_i`[1:0] is ignored, and all traps use base.

## Structure
- `tcore_param` additions:
  - `trap_state_e`
  - cause-code localparams `CAUSE_*`
  - `IRQ_FLAG_BIT`=XLEN-1
  - reuse of the existing `exc_type_e`
- Sub-module `trap_irq_arbiter`:
  - Parametrised by NUM_IRQ.
  - Input: pending vector.
  - Outputs: `irq_valid` and `irq_idx` of width $clog2(NUM_IRQ) (min 1).
  - Purely combinational priority encoder.

## Test plan
- Illegal instruction:
  - Stimulus: pc=0x100, tval=0xDEADBEEF, mtvec=0x2000.
  - Response: commit 0 at cycle 0; mcause=2, mepc=0x100, mtval=0xDEADBEEF at cycle 1; redirect 0x2000 at cycle 2.
- Interrupt versus exception:
  - Stimulus: `irq_i`=4'b0110, enables all, MIE=1, with a LOAD_MIS on the same instruction.
  - Response: mcause=0x80000011, mtval=0, mepc=`wb_pc_i`.
- MIE gating: `mie_i`=0 with `irq_i` asserted and a clean instruction -> `commit_o`=1 and no trap.
- Vectored dispatch, with the macro defined:
  - Stimulus: mtvec=0x3001, `irq_i`[2].
  - Response: redirect 0x3000+4×18=0x3048. Without the macro the redirect is 0x3000.
- `mret` with mepc=0x400 and `redirect_ready_i` low for 5 cycles:
  - One `csr_mret_o` pulse.
  - Redirect 0x400 held for 5 cycles, then IDLE.
- Reset in REDIRECT: `rst_ni`=0 for one edge -> all outputs 0 and IDLE, with no second strobe.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared types and constants for the writeback trap/return controller:
//   exc_type_e    - exception class reported by the writeback stage
//   trap_state_e  - controller FSM states
//   CAUSE_*       - mcause exception codes
//   IRQ_FLAG_BIT  - mcause interrupt flag position for the default datapath
//   exc_cause()   - exception class -> mcause code
//   exc_keeps_tval() - whether the exception reports exc_tval in mtval
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

  localparam int TCORE_XLEN   = 32;
  localparam int IRQ_FLAG_BIT = TCORE_XLEN - 1;

  typedef enum logic [3:0] {
    NO_EXCEPTION           = 4'd0,
    EXC_INSTR_ACCESS_FAULT = 4'd1,
    EXC_ILLEGAL            = 4'd2,
    EXC_EBREAK             = 4'd3,
    EXC_LOAD_MIS           = 4'd4,
    EXC_LOAD_AF            = 4'd5,
    EXC_STORE_MIS          = 4'd6,
    EXC_STORE_AF           = 4'd7,
    EXC_ECALL              = 4'd8
  } exc_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP_WR  = 2'd1,
    MRET_WR  = 2'd2,
    REDIRECT = 2'd3
  } trap_state_e;

  localparam logic [4:0] CAUSE_INSTR_ACCESS_FAULT = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL            = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK             = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MIS           = 5'd4;
  localparam logic [4:0] CAUSE_LOAD_AF            = 5'd5;
  localparam logic [4:0] CAUSE_STORE_MIS          = 5'd6;
  localparam logic [4:0] CAUSE_STORE_AF           = 5'd7;
  localparam logic [4:0] CAUSE_ECALL              = 5'd11;

  function automatic logic [4:0] exc_cause(input exc_type_e exc);
    logic [4:0] code;
    code = 5'd0;
    case (exc)
      EXC_INSTR_ACCESS_FAULT: code = CAUSE_INSTR_ACCESS_FAULT;
      EXC_ILLEGAL:            code = CAUSE_ILLEGAL;
      EXC_EBREAK:             code = CAUSE_EBREAK;
      EXC_LOAD_MIS:           code = CAUSE_LOAD_MIS;
      EXC_LOAD_AF:            code = CAUSE_LOAD_AF;
      EXC_STORE_MIS:          code = CAUSE_STORE_MIS;
      EXC_STORE_AF:           code = CAUSE_STORE_AF;
      EXC_ECALL:              code = CAUSE_ECALL;
      default:                code = 5'd0;
    endcase
    return code;
  endfunction

  // ebreak and ecall carry no faulting value; mtval is written as zero.
  function automatic logic exc_keeps_tval(input exc_type_e exc);
    return !((exc == EXC_EBREAK) || (exc == EXC_ECALL));
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_ctrl_if
// Fetch redirect handshake between the trap controller and the fetch stage.
//   redirect_valid - redirect request (held until accepted)
//   redirect_pc    - redirect target, stable while redirect_valid is high
//   redirect_ready - fetch accepts the redirect this cycle
// Modports: master (trap controller side), slave (fetch side).
// -----------------------------------------------------------------------------
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_ctrl_irq_arbiter.sv
// -----------------------------------------------------------------------------
// trap_irq_arbiter
// Combinational fixed-priority encoder over the pending interrupt vector;
// the lowest index wins.
//   pending_i   in  NUM_IRQ : enabled and pending interrupt lines
//   irq_valid_o out 1       : at least one line pending
//   irq_idx_o   out IDX_W   : index of the winning line (0 when none)
// -----------------------------------------------------------------------------
module trap_irq_arbiter #(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] pending_i,
  output logic               irq_valid_o,
  output logic [IDX_W-1:0]   irq_idx_o
);

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    irq_valid_o = 1'b0;
    irq_idx_o   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        irq_valid_o = 1'b1;
        irq_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Trap and return controller at the writeback boundary. Detects interrupts,
// exceptions and mret on the retiring instruction, suppresses its commit,
// flushes the pipe, strobes the CSR trap/mret update and holds a fetch
// redirect until accepted.
//
// Optional feature: define TCORE_VECTORED_IRQ_EN to enable vectored interrupt
// dispatch (mtvec mode 2'b01 -> base + 4*cause for interrupts).
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   wb_valid_i, wb_pc_i        writeback instruction present / its PC
//   exc_type_i, exc_tval_i     writeback exception and faulting value
//   is_mret_i                  writeback instruction is mret
//   irq_i, irq_en_i, mie_i     interrupt lines, mie bits, mstatus.MIE
//   mtvec_i, mepc_i            current trap vector / exception PC CSRs
//   redir_if (master)          fetch redirect handshake
//   commit_o, flush_o, busy_o  commit permit, pipe flush, FSM busy
//   csr_trap_we_o              one-cycle trap CSR write strobe
//   csr_mepc_o/mcause_o/mtval_o latched trap CSR values
//   csr_mret_o                 one-cycle mret strobe
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_BASE_CAUSE = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wb_valid_i,
  input  logic [XLEN-1:0]    wb_pc_i,
  input  exc_type_e          exc_type_i,
  input  logic [XLEN-1:0]    exc_tval_i,
  input  logic               is_mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               mie_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic [XLEN-1:0]    mepc_i,
  trap_ctrl_if.master        redir_if,
  output logic               commit_o,
  output logic               flush_o,
  output logic               busy_o,
  output logic               csr_trap_we_o,
  output logic [XLEN-1:0]    csr_mepc_o,
  output logic [XLEN-1:0]    csr_mcause_o,
  output logic [XLEN-1:0]    csr_mtval_o,
  output logic               csr_mret_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [NUM_IRQ-1:0] pending;
  logic               irq_valid;
  logic [IDX_W-1:0]   irq_idx;
  logic [XLEN-1:0]    irq_cause;
  logic [XLEN-1:0]    trap_base;
  logic [XLEN-1:0]    trap_target;
  logic               redirect_valid;

  assign pending = irq_i & irq_en_i & {NUM_IRQ{mie_i}};

  trap_irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_irq_arbiter (
    .pending_i   (pending),
    .irq_valid_o (irq_valid),
    .irq_idx_o   (irq_idx)
  );

  assign irq_cause = XLEN'(IRQ_BASE_CAUSE) + XLEN'(irq_idx);
  assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TCORE_VECTORED_IRQ_EN
  // mcause_q already holds the cause code; its flag bit marks an interrupt.
  assign trap_target = (mcause_q[XLEN-1] && (mtvec_i[1:0] == 2'b01))
                     ? trap_base + {mcause_q[XLEN-3:0], 2'b00}
                     : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
  assign trap_target = trap_base;
`endif

  always_comb begin
    state_d        = state_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    target_d       = target_q;
    commit_o       = 1'b0;
    flush_o        = 1'b0;
    csr_trap_we_o  = 1'b0;
    csr_mret_o     = 1'b0;
    redirect_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        commit_o = wb_valid_i;
        if (wb_valid_i) begin
          if (irq_valid) begin
            // Interrupt beats any exception on the same instruction.
            mepc_d              = wb_pc_i;
            mcause_d            = irq_cause;
            mcause_d[XLEN-1]    = 1'b1;
            mtval_d             = '0;
            state_d             = TRAP_WR;
            commit_o            = 1'b0;
            flush_o             = 1'b1;
          end else if (exc_type_i != NO_EXCEPTION) begin
            mepc_d   = wb_pc_i;
            mcause_d = XLEN'(exc_cause(exc_type_i));
            mtval_d  = exc_keeps_tval(exc_type_i) ? exc_tval_i : '0;
            state_d  = TRAP_WR;
            commit_o = 1'b0;
            flush_o  = 1'b1;
          end else if (is_mret_i) begin
            state_d  = MRET_WR;
            commit_o = 1'b0;
            flush_o  = 1'b1;
          end
        end
      end
      TRAP_WR: begin
        csr_trap_we_o = 1'b1;
        flush_o       = 1'b1;
        target_d      = trap_target;
        state_d       = REDIRECT;
      end
      MRET_WR: begin
        csr_mret_o = 1'b1;
        flush_o    = 1'b1;
        target_d   = mepc_i;
        state_d    = REDIRECT;
      end
      REDIRECT: begin
        flush_o        = 1'b1;
        redirect_valid = 1'b1;
        if (redir_if.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held nothing leaves the block, so a reset landing on a
    // strobe cycle cannot produce a partial CSR update or redirect.
    if (!rst_ni) begin
      commit_o       = 1'b0;
      flush_o        = 1'b0;
      csr_trap_we_o  = 1'b0;
      csr_mret_o     = 1'b0;
      redirect_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      target_q <= target_d;
    end
  end

  assign busy_o                  = (state_q != IDLE);
  assign csr_mepc_o              = mepc_q;
  assign csr_mcause_o            = mcause_q;
  assign csr_mtval_o             = mtval_q;
  assign redir_if.redirect_valid = redirect_valid;
  assign redir_if.redirect_pc    = target_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int NIRQ = 4;
`ifdef TCORE_VECTORED_IRQ_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            wb_valid;
  logic [31:0]     wb_pc;
  exc_type_e       exc_type;
  logic [31:0]     exc_tval;
  logic            is_mret;
  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] irq_en;
  logic            mie;
  logic [31:0]     mtvec;
  logic [31:0]     mepc;
  logic            commit_o, flush_o, busy_o, csr_trap_we_o, csr_mret_o;
  logic [31:0]     csr_mepc_o, csr_mcause_o, csr_mtval_o;

  int checks = 0;
  int errors = 0;
  int trap_cnt = 0;
  int mret_cnt = 0;

  trap_ctrl_if #(.XLEN(32)) rif ();

  trap_ctrl #(.XLEN(32), .NUM_IRQ(NIRQ), .IRQ_BASE_CAUSE(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wb_valid_i    (wb_valid),
    .wb_pc_i       (wb_pc),
    .exc_type_i    (exc_type),
    .exc_tval_i    (exc_tval),
    .is_mret_i     (is_mret),
    .irq_i         (irq),
    .irq_en_i      (irq_en),
    .mie_i         (mie),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .redir_if      (rif),
    .commit_o      (commit_o),
    .flush_o       (flush_o),
    .busy_o        (busy_o),
    .csr_trap_we_o (csr_trap_we_o),
    .csr_mepc_o    (csr_mepc_o),
    .csr_mcause_o  (csr_mcause_o),
    .csr_mtval_o   (csr_mtval_o),
    .csr_mret_o    (csr_mret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (csr_trap_we_o) trap_cnt++;
    if (csr_mret_o)    mret_cnt++;
  end

  // Reference model: what the controller must do for one writeback instruction.
  // kind: 0 = plain commit, 1 = trap, 2 = mret.
  function automatic void model(input logic v, input logic [NIRQ-1:0] l, input logic [NIRQ-1:0] en,
                                input logic m, input exc_type_e e, input logic r,
                                input logic [31:0] pc, input logic [31:0] tv,
                                input logic [31:0] tvec, input logic [31:0] epc,
                                output int kind, output logic [31:0] x_mepc,
                                output logic [31:0] x_cause, output logic [31:0] x_tval,
                                output logic [31:0] x_target);
    int line;
    int code;
    logic [31:0] base;
    line = -1;
    for (int n = 0; n < NIRQ; n++)
      if (line < 0 && m && l[n] && en[n]) line = n;
    case (e)
      EXC_INSTR_ACCESS_FAULT: code = 1;
      EXC_ILLEGAL:            code = 2;
      EXC_EBREAK:             code = 3;
      EXC_LOAD_MIS:           code = 4;
      EXC_LOAD_AF:            code = 5;
      EXC_STORE_MIS:          code = 6;
      EXC_STORE_AF:           code = 7;
      EXC_ECALL:              code = 11;
      default:                code = 0;
    endcase
    base     = tvec & 32'hFFFF_FFFC;
    kind     = 0;
    x_mepc   = pc;
    x_cause  = 0;
    x_tval   = 0;
    x_target = base;
    if (!v) begin
      kind = 0;
    end else if (line >= 0) begin
      kind    = 1;
      x_cause = 32'h8000_0000 + 32'(16 + line);
      if (VEC && tvec[1:0] == 2'b01) x_target = base + 32'(4 * (16 + line));
    end else if (code > 0) begin
      kind    = 1;
      x_cause = 32'(code);
      x_tval  = (e == EXC_EBREAK || e == EXC_ECALL) ? 32'd0 : tv;
    end else if (r) begin
      kind     = 2;
      x_target = epc;
    end
  endfunction

  task automatic clean_inputs();
    wb_valid = 1'b0; is_mret = 1'b0; irq = '0; exc_type = NO_EXCEPTION;
    rif.redirect_ready = 1'b0;
  endtask

  // Drives one trapping/mret instruction through the full sequence and records
  // what was observed. Called at posedge+1 with the controller idle. While the
  // controller is busy the writeback inputs carry junk that must be ignored.
  task automatic do_sequence(input logic [31:0] pc, input exc_type_e e, input logic [31:0] tv,
                             input logic r, input logic [NIRQ-1:0] l, input logic [NIRQ-1:0] en,
                             input logic m, input logic [31:0] tvec, input logic [31:0] epc,
                             input int stall,
                             output logic det_commit, output logic det_flush,
                             output logic c1_we, output logic c1_mret,
                             output logic [31:0] o_mepc, output logic [31:0] o_cause,
                             output logic [31:0] o_tval,
                             output logic red_valid, output logic [31:0] red_pc,
                             output int held, output logic back_idle,
                             output int d_trap, output int d_mret);
    int t0, m0;
    t0 = trap_cnt; m0 = mret_cnt;
    wb_valid = 1'b1; wb_pc = pc; exc_type = e; exc_tval = tv; is_mret = r;
    irq = l; irq_en = en; mie = m; mtvec = tvec; mepc = epc; rif.redirect_ready = 1'b0;
    #1;
    det_commit = commit_o; det_flush = flush_o;
    @(posedge clk); #1;
    wb_valid = 1'b1; is_mret = 1'b1; irq = '1; irq_en = '1; mie = 1'b1; exc_type = EXC_ILLEGAL;
    exc_tval = 32'h5555_5555; wb_pc = 32'h7777_7770;
    #1;
    c1_we = csr_trap_we_o; c1_mret = csr_mret_o;
    o_mepc = csr_mepc_o; o_cause = csr_mcause_o; o_tval = csr_mtval_o;
    @(posedge clk); #2;
    red_valid = rif.redirect_valid; red_pc = rif.redirect_pc;
    held = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #2;
      if (rif.redirect_valid && rif.redirect_pc === red_pc && !csr_trap_we_o && !csr_mret_o) held++;
    end
    rif.redirect_ready = 1'b1;
    @(posedge clk); #1;
    clean_inputs();
    #1;
    back_idle = !busy_o && !rif.redirect_valid;
    @(negedge clk);
    d_trap = trap_cnt - t0; d_mret = mret_cnt - m0;
    @(posedge clk); #1;
  endtask

  logic        s_dc, s_df, s_we, s_mr, s_rv, s_idle;
  logic [31:0] s_mepc, s_cause, s_tval, s_rpc;
  int          s_held, s_dt, s_dm;

  task automatic test_reset();
    rst_n = 1'b0;
    clean_inputs();
    wb_pc = '0; exc_tval = '0; irq_en = '0; mie = 1'b0; mtvec = '0; mepc = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({commit_o, flush_o, busy_o, rif.redirect_valid, csr_trap_we_o, csr_mret_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {commit_o, flush_o, busy_o, rif.redirect_valid, csr_trap_we_o, csr_mret_o});
    end
    checks++;
    if (rif.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", rif.redirect_pc); end
    checks++;
    if ({csr_mepc_o, csr_mcause_o, csr_mtval_o} !== 96'h0) begin
      errors++; $display("FAIL reset_csr: got %h %h %h want 0", csr_mepc_o, csr_mcause_o, csr_mtval_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("txn reset done");
  endtask

  task automatic test_illegal();
    do_sequence(32'h100, EXC_ILLEGAL, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 32'h2000, 32'h0, 0,
                s_dc, s_df, s_we, s_mr, s_mepc, s_cause, s_tval, s_rv, s_rpc, s_held, s_idle, s_dt, s_dm);
    $display("txn illegal: cause=%h mepc=%h mtval=%h redirect=%h", s_cause, s_mepc, s_tval, s_rpc);
    checks++; if (s_dc !== 1'b0 || s_df !== 1'b1) begin errors++; $display("FAIL illegal_detect: commit=%b flush=%b want 0/1", s_dc, s_df); end
    checks++; if (s_we !== 1'b1 || s_mr !== 1'b0) begin errors++; $display("FAIL illegal_strobe: we=%b mret=%b want 1/0", s_we, s_mr); end
    checks++; if (s_cause !== 32'd2) begin errors++; $display("FAIL illegal_mcause: got %h want 2", s_cause); end
    checks++; if (s_mepc !== 32'h100) begin errors++; $display("FAIL illegal_mepc: got %h want 100", s_mepc); end
    checks++; if (s_tval !== 32'hDEADBEEF) begin errors++; $display("FAIL illegal_mtval: got %h want deadbeef", s_tval); end
    checks++; if (s_rv !== 1'b1 || s_rpc !== 32'h2000) begin errors++; $display("FAIL illegal_redirect: valid=%b pc=%h want 1/2000", s_rv, s_rpc); end
    checks++; if (s_idle !== 1'b1 || s_dt != 1) begin errors++; $display("FAIL illegal_end: idle=%b strobes=%0d want 1/1", s_idle, s_dt); end
  endtask

  task automatic test_irq_vs_exc();
    do_sequence(32'h0000_0A40, EXC_LOAD_MIS, 32'h1234_5679, 1'b0, 4'b0110, 4'b1111, 1'b1, 32'h2000, 32'h0, 1,
                s_dc, s_df, s_we, s_mr, s_mepc, s_cause, s_tval, s_rv, s_rpc, s_held, s_idle, s_dt, s_dm);
    $display("txn irq_vs_exc: cause=%h mepc=%h mtval=%h redirect=%h", s_cause, s_mepc, s_tval, s_rpc);
    checks++; if (s_cause !== 32'h8000_0011) begin errors++; $display("FAIL irq_vs_exc_mcause: got %h want 80000011", s_cause); end
    checks++; if (s_tval !== 32'h0) begin errors++; $display("FAIL irq_vs_exc_mtval: got %h want 0", s_tval); end
    checks++; if (s_mepc !== 32'h0000_0A40) begin errors++; $display("FAIL irq_vs_exc_mepc: got %h want a40", s_mepc); end
    checks++; if (s_held != 1 || s_dt != 1) begin errors++; $display("FAIL irq_vs_exc_hold: held=%0d strobes=%0d want 1/1", s_held, s_dt); end
  endtask

  task automatic test_mie_gating();
    wb_valid = 1'b1; wb_pc = 32'h200; exc_type = NO_EXCEPTION; is_mret = 1'b0;
    irq = '1; irq_en = '1; mie = 1'b0;
    #1;
    $display("txn mie_gating: commit=%b flush=%b", commit_o, flush_o);
    checks++; if (commit_o !== 1'b1 || flush_o !== 1'b0) begin errors++; $display("FAIL mie_gating_commit: commit=%b flush=%b want 1/0", commit_o, flush_o); end
    @(posedge clk); #2;
    checks++; if (busy_o !== 1'b0 || csr_trap_we_o !== 1'b0) begin errors++; $display("FAIL mie_gating_notrap: busy=%b we=%b want 0/0", busy_o, csr_trap_we_o); end
    clean_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_vectored();
    logic [31:0] want;
    want = VEC ? 32'h3048 : 32'h3000;
    do_sequence(32'h300, NO_EXCEPTION, 32'h0, 1'b0, 4'b0100, 4'b1111, 1'b1, 32'h3001, 32'h0, 0,
                s_dc, s_df, s_we, s_mr, s_mepc, s_cause, s_tval, s_rv, s_rpc, s_held, s_idle, s_dt, s_dm);
    $display("txn vectored_irq: cause=%h redirect=%h", s_cause, s_rpc);
    checks++; if (s_rpc !== want) begin errors++; $display("FAIL vectored_irq_target: got %h want %h", s_rpc, want); end
    do_sequence(32'h304, EXC_ECALL, 32'hABCD_0000, 1'b0, '0, 4'b1111, 1'b1, 32'h3001, 32'h0, 0,
                s_dc, s_df, s_we, s_mr, s_mepc, s_cause, s_tval, s_rv, s_rpc, s_held, s_idle, s_dt, s_dm);
    $display("txn vectored_ecall: cause=%h mtval=%h redirect=%h", s_cause, s_tval, s_rpc);
    checks++; if (s_rpc !== 32'h3000) begin errors++; $display("FAIL vectored_exc_target: got %h want 3000", s_rpc); end
    checks++; if (s_cause !== 32'd11 || s_tval !== 32'h0) begin errors++; $display("FAIL ecall_csr: cause=%h mtval=%h want b/0", s_cause, s_tval); end
  endtask

  task automatic test_mret_stall();
    do_sequence(32'h500, NO_EXCEPTION, 32'h0, 1'b1, '0, '0, 1'b0, 32'h2000, 32'h400, 5,
                s_dc, s_df, s_we, s_mr, s_mepc, s_cause, s_tval, s_rv, s_rpc, s_held, s_idle, s_dt, s_dm);
    $display("txn mret: redirect=%h held=%0d pulses=%0d", s_rpc, s_held, s_dm);
    checks++; if (s_mr !== 1'b1 || s_we !== 1'b0) begin errors++; $display("FAIL mret_strobe: mret=%b we=%b want 1/0", s_mr, s_we); end
    checks++; if (s_rv !== 1'b1 || s_rpc !== 32'h400) begin errors++; $display("FAIL mret_redirect: valid=%b pc=%h want 1/400", s_rv, s_rpc); end
    checks++; if (s_held != 5) begin errors++; $display("FAIL mret_hold: got %0d cycles want 5", s_held); end
    checks++; if (s_dm != 1 || s_dt != 0 || s_idle !== 1'b1) begin
      errors++; $display("FAIL mret_end: mret pulses=%0d trap pulses=%0d idle=%b want 1/0/1", s_dm, s_dt, s_idle);
    end
  endtask

  task automatic test_reset_in_redirect();
    int t0;
    t0 = trap_cnt;
    wb_valid = 1'b1; wb_pc = 32'h600; exc_type = EXC_STORE_AF; exc_tval = 32'h99; mtvec = 32'h2000;
    irq = '0; is_mret = 1'b0; rif.redirect_ready = 1'b0;
    @(posedge clk); #1;
    clean_inputs();
    @(posedge clk); #2;
    checks++; if (rif.redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_redirect_reached: valid=%b want 1", rif.redirect_valid); end
    rst_n = 1'b0;
    @(posedge clk); #2;
    $display("txn reset_in_redirect: busy=%b valid=%b", busy_o, rif.redirect_valid);
    checks++;
    if ({busy_o, rif.redirect_valid, flush_o, commit_o, csr_trap_we_o, csr_mret_o} !== 6'b0 ||
        rif.redirect_pc !== 32'h0 || csr_mcause_o !== 32'h0 || csr_mepc_o !== 32'h0 || csr_mtval_o !== 32'h0) begin
      errors++; $display("FAIL rst_redirect_outputs: busy=%b valid=%b pc=%h mcause=%h want all 0",
                         busy_o, rif.redirect_valid, rif.redirect_pc, csr_mcause_o);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (trap_cnt - t0 != 1 || busy_o !== 1'b0 || rif.redirect_valid !== 1'b0) begin
      errors++; $display("FAIL rst_redirect_after: strobes=%0d busy=%b valid=%b want 1/0/0",
                         trap_cnt - t0, busy_o, rif.redirect_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int kind, stall;
    logic v, r, m;
    logic [NIRQ-1:0] l, en;
    exc_type_e e;
    logic [31:0] pc, tv, tvec, epc, tmp, x_mepc, x_cause, x_tval, x_target;
    for (int t = 0; t < 40; t++) begin
      v    = ($urandom_range(0, 9) != 0);
      l    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      en   = 4'($urandom_range(0, 15));
      m    = 1'($urandom_range(0, 1));
      e    = ($urandom_range(0, 1) == 0) ? NO_EXCEPTION : exc_type_e'(4'($urandom_range(1, 8)));
      r    = 1'($urandom_range(0, 1));
      pc   = $urandom() & 32'hFFFF_FFFC;
      tv   = $urandom();
      tmp  = $urandom();
      tvec = {tmp[31:2], 1'b0, 1'($urandom_range(0, 1))};
      epc  = $urandom() & 32'hFFFF_FFFC;
      stall = $urandom_range(0, 3);
      model(v, l, en, m, e, r, pc, tv, tvec, epc, kind, x_mepc, x_cause, x_tval, x_target);
      if (kind == 0) begin
        wb_valid = v; wb_pc = pc; exc_type = e; exc_tval = tv; is_mret = r;
        irq = l; irq_en = en; mie = m; mtvec = tvec; mepc = epc;
        #1;
        $display("txn rnd %0d commit v=%b commit=%b flush=%b", t, v, commit_o, flush_o);
        checks++;
        if (commit_o !== v || flush_o !== 1'b0) begin
          errors++; $display("FAIL rnd_commit[%0d]: commit=%b flush=%b want %b/0", t, commit_o, flush_o, v);
        end
        @(posedge clk); #2;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rnd_nobusy[%0d]: busy=%b want 0", t, busy_o); end
        clean_inputs();
        @(posedge clk); #1;
      end else begin
        do_sequence(pc, e, tv, r, l, en, m, tvec, epc, stall,
                    s_dc, s_df, s_we, s_mr, s_mepc, s_cause, s_tval, s_rv, s_rpc, s_held, s_idle, s_dt, s_dm);
        $display("txn rnd %0d kind=%0d cause=%h mepc=%h mtval=%h redirect=%h", t, kind, s_cause, s_mepc, s_tval, s_rpc);
        checks++;
        if (s_dc !== 1'b0 || s_df !== 1'b1) begin errors++; $display("FAIL rnd_detect[%0d]: commit=%b flush=%b want 0/1", t, s_dc, s_df); end
        checks++;
        if (s_rv !== 1'b1 || s_rpc !== x_target) begin errors++; $display("FAIL rnd_redirect[%0d]: valid=%b pc=%h want 1/%h", t, s_rv, s_rpc, x_target); end
        checks++;
        if (s_held != stall || s_idle !== 1'b1) begin errors++; $display("FAIL rnd_hold[%0d]: held=%0d idle=%b want %0d/1", t, s_held, s_idle, stall); end
        checks++;
        if (kind == 1) begin
          if (s_dt != 1 || s_dm != 0 || s_mepc !== x_mepc || s_cause !== x_cause || s_tval !== x_tval) begin
            errors++; $display("FAIL rnd_trap[%0d]: strobes=%0d/%0d mepc=%h cause=%h tval=%h want 1/0 %h %h %h",
                               t, s_dt, s_dm, s_mepc, s_cause, s_tval, x_mepc, x_cause, x_tval);
          end
        end else begin
          if (s_dm != 1 || s_dt != 0) begin
            errors++; $display("FAIL rnd_mret[%0d]: mret=%0d trap=%0d want 1/0", t, s_dm, s_dt);
          end
        end
      end
    end
  endtask

  initial begin
    rif.redirect_ready = 1'b0;
    test_reset();
    test_illegal();
    test_irq_vs_exc();
    test_mie_gating();
    test_vectored();
    test_mret_stall();
    test_reset_in_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
